// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the single-cycle datapath and a valid/ready word bus.
// Stalls the core for the whole access and reports misaligned, illegal or timed-out accesses.
module lsu_bus_bridge #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, FAULT} state_t;

  state_t            state_q, state_d;
  logic [29:0]       waddr_q, waddr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]   cnt_inc;
  logic              timed_out;
  logic              op_req;
  logic              misaligned;
  logic              illegal;
  logic              unused_f3;

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_lanes(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] rd);
    case (size)
      2'b00:   load_lanes = rd >> {off, 3'b000};
      2'b01:   load_lanes = rd >> {off[1], 4'b0000};
      default: load_lanes = rd;
    endcase
  endfunction

  // Signedness bit only matters to the downstream extend stage.
  assign unused_f3 = funct3[2];

  assign op_req     = MemRead | MemWrite;
  assign misaligned = ((funct3[1:0] == 2'b01) && ALUResult[0]) ||
                      ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
  assign illegal    = (MemRead & MemWrite) || (funct3[1:0] == 2'b11) || misaligned;

  assign cnt_inc   = cnt_q + 1'b1;
  assign timed_out = (cnt_inc == TO_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    size_d  = size_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    Stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_req) begin
          Stall = 1'b1;
          if (illegal) begin
            state_d = FAULT;
          end else begin
            waddr_d = ALUResult[31:2];
            we_d    = MemWrite;
            wdata_d = store_lanes(funct3[1:0], WriteData);
            be_d    = MemWrite ? store_be(funct3[1:0], ALUResult[1:0]) : 4'b1111;
            size_d  = funct3[1:0];
            off_d   = ALUResult[1:0];
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        Stall = 1'b1;
        cnt_d = cnt_inc;
        // An accepted handshake wins over a timeout landing in the same cycle.
        if (bus_req_ready)  state_d = WAIT;
        else if (timed_out) state_d = FAULT;
      end
      WAIT: begin
        Stall = 1'b1;
        cnt_d = cnt_inc;
        if (bus_resp_valid) begin
          rdata_d = bus_rdata;
          state_d = DONE;
        end else if (timed_out) begin
          state_d = FAULT;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus-facing registers are reset too so the bus sees all zeros while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      waddr_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_req_valid = (state_q == REQ);
  assign bus_we        = we_q;
  assign bus_addr      = {waddr_q, 2'b00};
  assign bus_wdata     = wdata_q;
  assign bus_be        = be_q;
  assign MemFault      = (state_q == FAULT);
  assign ReadData      = ((state_q == DONE) && !we_q) ? load_lanes(size_q, off_q, rdata_q) : 32'h0;

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit directly downstream of the single-cycle datapath: consumes ALUResult (address), WriteData and funct3; produces ReadData for the datapath's load-select/extend stage.
- Converts each memory instruction into a valid/ready request plus a response-wait on a word-wide data bus.
- Asserts Stall so the core holds PC and instr until the access completes.
- Generates byte enables, replicates store data, lane-shifts load data, detects misalignment and bus timeout.

Parameters:
- TIMEOUT, 255, max cycles spent in REQ+WAIT before abort; range 1..2**TO_W-1.
- TO_W, 8, timeout counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  current instruction is a load.
- MemWrite  in  1  current instruction is a store.
- funct3  in  3  instr[14:12]; [1:0]=00 byte, 01 half, 10 word; bit2 ignored here.
- ALUResult  in  32  byte address.
- WriteData  in  32  store data (rs2).
- ReadData  out  32  load data, addressed byte/half in low bits; zero-extension/sign-extension done downstream.
- Stall  out  1  hold PC/instr/regfile write this cycle.
- MemFault  out  1  one-cycle pulse: misaligned, illegal, or timed-out access.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_we  out  1  1=write.
- bus_addr  out  32  word address {ALUResult[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables (writes); 4'b1111 on reads.
- bus_resp_valid  in  1  response/write-ack valid.
- bus_rdata  in  32  read data, valid with bus_resp_valid.

Behaviour:
- Reset (reset=0, any time, async): state IDLE; bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, ReadData=0, MemFault=0, timeout counter=0. Any in-flight transaction is abandoned; no response is later consumed.
- States: IDLE, REQ, WAIT, DONE, FAULT.
- IDLE: no MemRead/MemWrite -> Stall=0, stay. Legal aligned op -> Stall=1 (combinational), register addr/we/wdata/be/funct3/addr[1:0], clear counter, go REQ.
- IDLE illegal op (MemRead&MemWrite; funct3[1:0]=11; half with addr[0]=1; word with addr[1:0]!=0) -> go FAULT, no bus request, Stall=1 this cycle.
- REQ: bus_req_valid=1; outputs held stable until bus_req_ready=1, then go WAIT. Stall=1.
- WAIT: bus_req_valid=0; on bus_resp_valid=1 latch bus_rdata, go DONE. Stall=1. bus_resp_valid is ignored outside WAIT.
- DONE: Stall=0 for exactly one cycle; ReadData valid (0 for stores). Instruction retires; next state IDLE.
- FAULT: Stall=0, MemFault=1, ReadData=0 for one cycle; next state IDLE. Write suppression on fault is the controller's job.
- Timeout: counter increments every cycle in REQ or WAIT. When it reaches TIMEOUT, go FAULT; bus_req_valid drops the next cycle even without ready.
- Store lanes: byte -> wdata={4{WriteData[7:0]}}, be=4'b0001<<addr[1:0]. Half -> wdata={2{WriteData[15:0]}}, be=addr[1]?4'b1100:4'b0011. Word -> wdata=WriteData, be=4'b1111.
- Load lanes: ReadData = latched_rdata >> (8*addr[1:0]) for byte, >> (16*addr[1]) for half, unshifted for word. Upper bits are whatever the shift leaves. ReadData=0 outside DONE.
- Latency: ready=1 in first REQ cycle and response the next cycle -> Stall high 3 cycles (IDLE, REQ, WAIT); DONE in cycle 4.
- Every memory instruction incurs at least one Stall cycle.

Test Plan:
- lw addr 0x100, ready=1 immediately, resp next cycle rdata 0xDEADBEEF -> Stall 1,1,1,0; DONE ReadData=0xDEADBEEF; bus_addr=0x100, be=1111, we=0.
- lb addr 0x103, rdata 0xAABBCCDD -> bus_addr=0x100, DONE ReadData[7:0]=0xAA; lh addr 0x102 same rdata -> ReadData[15:0]=0xAABB.
- sh addr 0x202, WriteData 0x00001234 -> bus_wdata=0x12341234, be=1100, we=1; ack one cycle later -> DONE, MemFault=0.
- lw addr 0x101 -> no bus_req_valid ever; Stall=1 for one cycle then MemFault=1 with Stall=0 for one cycle, then IDLE.
- sb addr 0x3, bus_req_ready held 0 for 5 cycles -> bus_req_valid, addr, wdata=0x..repl, be=1000 stable all 5 cycles; completes normally after ready.
- TIMEOUT=4, ready never asserted -> FAULT reached after 4 REQ cycles, MemFault pulse, req_valid drops. Repeat, asserting reset=0 mid-WAIT -> all outputs 0 immediately; a later resp_valid is ignored.
